// File: rtl/sroute_port_arbiter.sv
// sroute_port_arbiter: packet-level round-robin arbiter that shares the single
// packet-memory write port among NPORTS receiver ports. A grant is held for a
// whole packet and that port's beats are forwarded as memory writes.
//
// Beat handshake: a beat from the granted port g is offered when pushin[g]=1.
// It is accepted (written, wr_en=1) in the same cycle only if mem_full=0.
// When mem_full=1, stall is raised and the offered beat is dropped. A dropped
// beat is flagged by a one-cycle overflow pulse on the following cycle.
// Beats from ports that do not hold the grant are never accepted.
module sroute_port_arbiter #(
    parameter int NPORTS  = 32,
    parameter int PW      = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NPORTS-1:0] enabled,
    input  logic [NPORTS-1:0] request,
    input  logic [NPORTS-1:0] pushin,
    input  logic [NPORTS-1:0] lastin,
    input  logic              mem_full,
    output logic [NPORTS-1:0] ack,
    output logic              grant_valid,
    output logic [PW-1:0]     grant_port,
    output logic              wr_en,
    output logic              wr_last,
    output logic              stall,
    output logic              abort,
    output logic              overflow,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_ABORT   = 2'd3
    } state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_t              state_q, state_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NPORTS-1:0]   ack_q, ack_d;
    logic                grant_valid_q, grant_valid_d;
    logic [PW-1:0]       grant_port_q, grant_port_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                overflow_q, overflow_d;

    logic [NPORTS-1:0]   eligible;
    logic                win_found;
    logic [PW-1:0]       win_idx;
    logic [PW-1:0]       scan_idx;

    logic                g_push;
    logic                g_last;
    logic                g_en;
    logic                g_done;

    assign g_push = pushin[grant_port_q];
    assign g_last = lastin[grant_port_q];
    assign g_en   = enabled[grant_port_q];
    assign g_done = g_push & g_last & ~mem_full;

    // Round-robin winner: first eligible port scanning upward from rr_ptr, wrapping.
    always_comb begin
        eligible  = request & enabled;
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < NPORTS; i++) begin
            scan_idx = rr_ptr_q + PW'(i);
            if (!win_found && eligible[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Next-state and write-path logic. RELEASE and ABORT are the single dead
    // cycle after a grant; they already arbitrate with the advanced pointer.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        ack_d         = ack_q;
        grant_valid_d = grant_valid_q;
        grant_port_d  = grant_port_q;
        cnt_d         = cnt_q;
        overflow_d    = 1'b0;
        wr_en         = 1'b0;
        wr_last       = 1'b0;

        case (state_q)
            ST_BUSY: begin
                wr_en      = g_push & ~mem_full;
                wr_last    = g_push & ~mem_full & g_last;
                overflow_d = g_push & mem_full;
                if (g_done) begin
                    // Completing last beat takes priority over disable/timeout.
                    state_d = ST_RELEASE;
                end else if (!g_en || (cnt_q == TO_LIM)) begin
                    state_d = ST_ABORT;
                end else begin
                    cnt_d = g_push ? 8'd0 : cnt_q + 8'd1;
                end
                if (state_d != ST_BUSY) begin
                    ack_d         = '0;
                    grant_valid_d = 1'b0;
                    rr_ptr_d      = grant_port_q + PW'(1);
                    cnt_d         = 8'd0;
                end
            end
            default: begin
                // IDLE, RELEASE, ABORT: arbitrate unless memory is full.
                if (win_found && !mem_full) begin
                    state_d       = ST_BUSY;
                    ack_d         = NPORTS'(1) << win_idx;
                    grant_valid_d = 1'b1;
                    grant_port_d  = win_idx;
                    cnt_d         = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State and grant registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            ack_q         <= '0;
            grant_valid_q <= 1'b0;
            grant_port_q  <= '0;
            cnt_q         <= 8'd0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            ack_q         <= ack_d;
            grant_valid_q <= grant_valid_d;
            grant_port_q  <= grant_port_d;
            cnt_q         <= cnt_d;
            overflow_q    <= overflow_d;
        end
    end

    assign ack         = ack_q;
    assign grant_valid = grant_valid_q;
    assign grant_port  = grant_port_q;
    assign stall       = grant_valid_q & mem_full;
    assign abort       = (state_q == ST_ABORT);
    assign overflow    = overflow_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_sroute_port_arbiter.sv
// Bench for sroute_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a packet-level model of the arbiter.
module tb_sroute_port_arbiter;

    localparam int NP = 32;
    localparam int PW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [NP-1:0] enabled, request, pushin, lastin;
    logic          mem_full;
    logic [NP-1:0] ack;
    logic          grant_valid, wr_en, wr_last, stall, abort, overflow;
    logic [PW-1:0] grant_port;
    logic [1:0]    state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    sroute_port_arbiter #(.NPORTS(NP), .PW(PW), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .enabled(enabled), .request(request),
        .pushin(pushin), .lastin(lastin), .mem_full(mem_full), .ack(ack),
        .grant_valid(grant_valid), .grant_port(grant_port), .wr_en(wr_en),
        .wr_last(wr_last), .stall(stall), .abort(abort), .overflow(overflow),
        .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Packet view: either a port owns the grant or nobody does. A grant ends on
    // an accepted last beat, a disabled owner, or 255 silent cycles; then the
    // pointer moves to owner+1 and the next arbitration happens a cycle later.
    bit            m_gv;
    int            m_g, m_ptr, m_silent;
    bit            m_abort, m_ovf;
    logic [NP-1:0] m_elig;
    bit            n_abort, n_ovf;

    function automatic int pick(input logic [NP-1:0] e, input int ptr);
        for (int i = 0; i < NP; i++)
            if (e[(ptr + i) % NP]) return (ptr + i) % NP;
        return -1;
    endfunction

    // Compare process: mid-cycle, inputs and outputs stable.
    always @(negedge clk) begin
        if (!reset) begin
            m_gv = 0; m_g = 0; m_ptr = 0; m_silent = 0; m_abort = 0; m_ovf = 0;
        end
        check("ack",         ack,         m_gv ? (32'h1 << m_g) : 32'h0);
        check("grant_valid", grant_valid, m_gv);
        if (m_gv) check("grant_port", grant_port, m_g);
        check("wr_en",   wr_en,   m_gv && pushin[m_g] && !mem_full);
        check("wr_last", wr_last, m_gv && pushin[m_g] && !mem_full && lastin[m_g]);
        check("stall",   stall,   m_gv && mem_full);
        check("abort",   abort,   m_abort);
        check("overflow", overflow, m_ovf);
        if (reset) begin
            n_abort = 0;
            n_ovf   = m_gv && pushin[m_g] && mem_full;
            if (m_gv) begin
                if (pushin[m_g] && lastin[m_g] && !mem_full) begin
                    m_gv = 0; m_ptr = (m_g + 1) % NP; m_silent = 0;
                end else if (!enabled[m_g] || m_silent == 255) begin
                    m_gv = 0; m_ptr = (m_g + 1) % NP; m_silent = 0; n_abort = 1;
                end else begin
                    m_silent = pushin[m_g] ? 0 : m_silent + 1;
                end
            end else begin
                m_elig = request & enabled;
                if (m_elig != 0 && !mem_full) begin
                    m_g = pick(m_elig, m_ptr); m_gv = 1; m_silent = 0;
                end
            end
            m_abort = n_abort;
            m_ovf   = n_ovf;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        request = '0; pushin = '0; lastin = '0; mem_full = 1'b0; enabled = '1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (3) tick();
        reset = 1'b1;
    endtask

    task automatic wait_grant(output int port, output int waited);
        port = -1;
        waited = 0;
        while (!grant_valid && waited < 40) begin
            tick();
            waited++;
        end
        if (grant_valid) port = int'(grant_port);
        else begin
            n_tests++; n_fail++;
            $display("FAIL wait_grant: no grant within 40 cycles at %0t", $time);
        end
    endtask

    task automatic send_pkt(input int p, input int nb);
        for (int b = 0; b < nb; b++) begin
            pushin = '0; lastin = '0;
            pushin[p] = 1'b1;
            lastin[p] = (b == nb - 1);
            tick();
        end
        pushin = '0; lastin = '0;
    endtask

    int p, w, ovf_seen, n;

    initial begin
        reset = 1'b0;
        idle_inputs();

        // 1: reset with random inputs, then first grant to lowest eligible index
        repeat (6) begin
            request = $urandom; enabled = $urandom; pushin = $urandom;
            lastin = $urandom; mem_full = 1'($urandom_range(0, 1));
            tick();
        end
        idle_inputs();
        request = 32'h0000_0090;
        reset = 1'b1;
        tick();
        check("first_grant_port", grant_port, 4);
        check("first_grant_ack", ack, 32'h0000_0010);
        request = 32'h0000_0080;
        send_pkt(4, 1);
        check("release_ack", ack, 32'h0);
        tick();
        check("second_grant_port", grant_port, 7);
        request = '0;
        send_pkt(7, 1);
        repeat (2) tick();

        // 2: round robin over all ports, 3-beat packets, one dead cycle
        do_reset();
        request = '1;
        for (int k = 0; k <= NP; k++) begin
            wait_grant(p, w);
            check("rr_order", p, k % NP);
            check("rr_dead_cycles", w, 1);
            send_pkt(p < 0 ? 0 : p, 3);
        end
        request = '0;
        repeat (2) tick();

        // 3: wrap with port 0 masked
        do_reset();
        request = 32'h2000_0000;
        wait_grant(p, w);
        check("wrap_setup", p, 29);
        request = 32'h8000_0003;
        enabled = 32'hFFFF_FFFE;
        send_pkt(29, 1);
        wait_grant(p, w);
        check("wrap_first", p, 31);
        send_pkt(31, 1);
        wait_grant(p, w);
        check("wrap_second", p, 1);
        request = '0;
        send_pkt(1, 1);
        idle_inputs();
        repeat (2) tick();

        // 4: back-pressure on port 5
        do_reset();
        request = 32'h0000_0020;
        wait_grant(p, w);
        check("bp_grant", p, 5);
        request = '0;
        pushin[5] = 1'b1;
        mem_full = 1'b1;
        #1;
        check("bp_stall", stall, 1);
        check("bp_wr_en", wr_en, 0);
        ovf_seen = 0;
        repeat (4) begin
            tick();
            if (overflow) ovf_seen++;
        end
        mem_full = 1'b0;
        tick();
        if (overflow) ovf_seen++;
        lastin[5] = 1'b1;
        tick();
        if (overflow) ovf_seen++;
        check("bp_overflow_pulses", ovf_seen, 4);
        idle_inputs();
        repeat (2) tick();

        // 5: abort on enable drop, then drop coinciding with last beat
        do_reset();
        request = 32'h0000_0204;
        wait_grant(p, w);
        check("ab_grant", p, 2);
        pushin[2] = 1'b1;
        tick();
        pushin = '0;
        enabled[2] = 1'b0;
        tick();
        check("ab_abort", abort, 1);
        check("ab_ack", ack, 32'h0);
        tick();
        check("ab_next_grant", grant_port, 9);
        check("ab_next_valid", grant_valid, 1);
        enabled[9] = 1'b0;
        pushin[9] = 1'b1;
        lastin[9] = 1'b1;
        #1;
        check("ab_last_wr_last", wr_last, 1);
        tick();
        check("ab_last_no_abort", abort, 0);
        idle_inputs();
        repeat (2) tick();

        // 6: timeout after 255 silent cycles
        do_reset();
        request = 32'h0000_1000;
        wait_grant(p, w);
        check("to_grant", p, 12);
        request = '0;
        n = 0;
        while (!abort && n < 400) begin
            tick();
            n++;
        end
        check("to_cycles", n, 256);
        request = 32'h0000_5000;
        tick();
        check("to_next_grant", grant_port, 14);
        idle_inputs();
        repeat (2) tick();

        // 7: randomized traffic with occasional reset
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            request  = $urandom & $urandom;
            enabled  = ($urandom_range(0, 19) == 0) ? $urandom : '1;
            pushin   = $urandom;
            lastin   = $urandom & $urandom;
            mem_full = ($urandom_range(0, 4) == 0);
            reset    = ($urandom_range(0, 499) != 0);
            tick();
        end
        reset = 1'b1;
        idle_inputs();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
